// File: rtl/mmu_pkg.sv
// mmu_pkg: shared TLB entry layout, memory-op and exception encodings,
// FSM state type and byte-lane helpers for the mmu_tlb slice.
// Optional feature: MMU_ASID_EN (ASID/G matching) is handled in the modules.
package mmu_pkg;

    // TLB entry field widths
    localparam int unsigned VPN2_W = 19;
    localparam int unsigned ASID_W = 8;
    localparam int unsigned PFN_W  = 20;

    // TLB entry field offsets (LSB first): V1 D1 PFN1 V0 D0 PFN0 G ASID VPN2
    localparam int unsigned V1_OFF   = 0;
    localparam int unsigned D1_OFF   = 1;
    localparam int unsigned PFN1_OFF = 2;
    localparam int unsigned V0_OFF   = 22;
    localparam int unsigned D0_OFF   = 23;
    localparam int unsigned PFN0_OFF = 24;
    localparam int unsigned G_OFF    = 44;
    localparam int unsigned ASID_OFF = 45;
    localparam int unsigned VPN2_OFF = 53;
    localparam int unsigned TLB_ENTRY_WIDTH = 72;

    localparam int unsigned MEM_OPT_WIDTH = 4;
    typedef enum logic [MEM_OPT_WIDTH-1:0] {
        MEM_NONE = 4'd0,
        MEM_LW   = 4'd1,
        MEM_LBS  = 4'd2,
        MEM_LBU  = 4'd3,
        MEM_LHS  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SW   = 4'd6,
        MEM_SB   = 4'd7,
        MEM_SH   = 4'd8
    } mem_opt_e;

    localparam int unsigned EC_WIDTH = 3;
    typedef enum logic [EC_WIDTH-1:0] {
        EC_NONE = 3'd0,
        EC_ADEL = 3'd1,
        EC_ADES = 3'd2,
        EC_TLBL = 3'd3,
        EC_TLBS = 3'd4,
        EC_MOD  = 3'd5
    } ec_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MERGE = 2'd1,
        ST_WRITE = 2'd2
    } mmu_state_e;

    // Extract and extend a load result from a little-endian memory word
    function automatic logic [31:0] load_align(input mem_opt_e opt,
                                               input logic [1:0] a,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (opt)
            MEM_LW:  return w;
            MEM_LBS: return {{24{b[7]}}, b};
            MEM_LBU: return {24'h0, b};
            MEM_LHS: return {{16{h[15]}}, h};
            MEM_LHU: return {16'h0, h};
            default: return '0;
        endcase
    endfunction

    // Insert the low byte/half of wd into the old word at the addressed lane
    function automatic logic [31:0] store_merge(input mem_opt_e opt,
                                                input logic [1:0] a,
                                                input logic [31:0] old,
                                                input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        if (opt == MEM_SB) begin
            case (a)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end else if (opt == MEM_SH) begin
            if (a[1]) r[31:16] = wd[15:0];
            else      r[15:0]  = wd[15:0];
        end else begin
            r = wd;
        end
        return r;
    endfunction

endpackage

// File: rtl/tlb_match.sv
// tlb_match: combinational VPN2 match across all TLB entries, lowest index wins.
// With MMU_ASID_EN defined, an entry also needs ASID==asid or G=1 to match.
module tlb_match
    import mmu_pkg::*;
#(
    parameter  int unsigned TLB_NR_ENTRY = 16,
    localparam int unsigned TLB_INDEX_W  = $clog2(TLB_NR_ENTRY)
) (
    input  logic [TLB_ENTRY_WIDTH-1:0] entries [TLB_NR_ENTRY],
`ifdef MMU_ASID_EN
    input  logic [ASID_W-1:0]          asid,
`endif
    input  logic [VPN2_W-1:0]          vpn2,
    output logic                       hit,
    output logic [TLB_INDEX_W-1:0]     index
);

    logic [TLB_NR_ENTRY-1:0] match;
    logic                    unused_fields;

    // Per-entry key comparison
    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < TLB_NR_ENTRY; i++) begin
`ifdef MMU_ASID_EN
            match[i] = (entries[i][VPN2_OFF +: VPN2_W] == vpn2) &&
                       (entries[i][G_OFF] || (entries[i][ASID_OFF +: ASID_W] == asid));
`else
            match[i] = (entries[i][VPN2_OFF +: VPN2_W] == vpn2);
`endif
        end
    end

    // Priority select: first (lowest) matching index, 0 when nothing matches
    always_comb begin
        hit   = 1'b0;
        index = '0;
        for (int unsigned i = 0; i < TLB_NR_ENTRY; i++) begin
            if (match[i] && !hit) begin
                hit   = 1'b1;
                index = TLB_INDEX_W'(i);
            end
        end
    end

    // Fields not involved in matching
    always_comb begin
        unused_fields = 1'b0;
        for (int unsigned i = 0; i < TLB_NR_ENTRY; i++) begin
            unused_fields = unused_fields ^ (^entries[i]);
        end
    end

endmodule

// File: rtl/mmu_tlb.sv
// mmu_tlb: address translation (direct kseg window + software-loaded TLB),
// access checking and a small load/store sequencer toward physical memory.
// Optional feature: MMU_ASID_EN adds the asid port and ASID/G matching.
module mmu_tlb
    import mmu_pkg::*;
#(
    parameter  int unsigned TLB_NR_ENTRY = 16,
    localparam int unsigned TLB_INDEX_W  = $clog2(TLB_NR_ENTRY)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tlb_we,
    input  logic [TLB_INDEX_W-1:0]     tlb_windex,
    input  logic [TLB_ENTRY_WIDTH-1:0] tlb_wentry,
    input  logic [VPN2_W-1:0]          tlb_probe_vpn2,
    output logic                       tlb_probe_hit,
    output logic [TLB_INDEX_W-1:0]     tlb_probe_index,
`ifdef MMU_ASID_EN
    input  logic [ASID_W-1:0]          asid,
`endif
    input  logic [31:0]                instr_addr,
    output logic [31:0]                instr_out,
    input  logic [MEM_OPT_WIDTH-1:0]   data_opt,
    input  logic [31:0]                data_addr,
    input  logic [31:0]                data_in,
    output logic [31:0]                data_out,
    output logic                       busy,
    output logic [EC_WIDTH-1:0]        exc_code,
    output logic [31:0]                dev_mem_addr,
    input  logic [31:0]                dev_mem_data_in,
    output logic [31:0]                dev_mem_data_out,
    output logic                       dev_mem_is_write,
    input  logic                       dev_mem_busy
);

    logic [TLB_ENTRY_WIDTH-1:0] tlb [TLB_NR_ENTRY];
    mmu_state_e                 state, state_n;
    logic [31:0]                wdata, wdata_n;
    mem_opt_e                   opt;
    logic [31:0]                vaddr, paddr;
    logic                       direct, odd;
    logic                       l_hit;
    logic [TLB_INDEX_W-1:0]     l_idx;
    logic [TLB_ENTRY_WIDTH-1:0] sel;
    logic                       pg_v, pg_d;
    logic [PFN_W-1:0]           pg_pfn;
    logic                       is_load, is_store, is_word, is_half;
    ec_e                        exc;
    logic                       clean;
    logic                       unused_bits;

    assign opt = mem_opt_e'(data_opt);

    // TLB storage: reset invalidates every page half, otherwise write on strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < TLB_NR_ENTRY; i++) begin
                tlb[i][V0_OFF] <= 1'b0;
                tlb[i][V1_OFF] <= 1'b0;
            end
        end else if (tlb_we) begin
            tlb[tlb_windex] <= tlb_wentry;
        end
    end

    tlb_match #(.TLB_NR_ENTRY(TLB_NR_ENTRY)) u_lookup (
        .entries (tlb),
`ifdef MMU_ASID_EN
        .asid    (asid),
`endif
        .vpn2    (vaddr[31:13]),
        .hit     (l_hit),
        .index   (l_idx)
    );

    tlb_match #(.TLB_NR_ENTRY(TLB_NR_ENTRY)) u_probe (
        .entries (tlb),
`ifdef MMU_ASID_EN
        .asid    (asid),
`endif
        .vpn2    (tlb_probe_vpn2),
        .hit     (tlb_probe_hit),
        .index   (tlb_probe_index)
    );

    // Address select and translation; V is checked on the winning entry only
    always_comb begin
        vaddr  = ((opt != MEM_NONE) || (state != ST_IDLE)) ? data_addr : instr_addr;
        direct = (vaddr[31:30] == 2'b10);
        odd    = vaddr[12];
        sel    = tlb[l_idx];
        pg_v   = odd ? sel[V1_OFF] : sel[V0_OFF];
        pg_d   = odd ? sel[D1_OFF] : sel[D0_OFF];
        pg_pfn = odd ? sel[PFN1_OFF +: PFN_W] : sel[PFN0_OFF +: PFN_W];
        paddr  = direct ? {3'b000, vaddr[28:0]} : {pg_pfn, vaddr[11:0]};
    end

    // Access classification; NONE means an instruction fetch (word)
    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        is_word  = 1'b0;
        is_half  = 1'b0;
        case (opt)
            MEM_NONE: is_word = 1'b1;
            MEM_LW:   begin is_load = 1'b1; is_word = 1'b1; end
            MEM_LBS,
            MEM_LBU:  is_load = 1'b1;
            MEM_LHS,
            MEM_LHU:  begin is_load = 1'b1; is_half = 1'b1; end
            MEM_SW:   begin is_store = 1'b1; is_word = 1'b1; end
            MEM_SB:   is_store = 1'b1;
            MEM_SH:   begin is_store = 1'b1; is_half = 1'b1; end
            default:  is_load = 1'b0;
        endcase
    end

    // Exception priority: alignment, then translation miss, then dirty check
    always_comb begin
        exc = EC_NONE;
        if ((is_word && (vaddr[1:0] != 2'b00)) || (is_half && vaddr[0]))
            exc = is_store ? EC_ADES : EC_ADEL;
        else if (!direct && !(l_hit && pg_v))
            exc = is_store ? EC_TLBS : EC_TLBL;
        else if (is_store && !direct && !pg_d)
            exc = EC_MOD;
        clean = (exc == EC_NONE);
    end

    // FSM state and write-data registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
            wdata <= '0;
        end else begin
            state <= state_n;
            wdata <= wdata_n;
        end
    end

    // Next state and outputs. In WRITE, busy follows dev_mem_busy so the cycle
    // the write is accepted is the one where busy drops and the store completes.
    always_comb begin
        state_n  = state;
        wdata_n  = wdata;
        busy     = 1'b0;
        is_write_c: begin end
        dev_mem_is_write = 1'b0;
        data_out = '0;
        case (state)
            ST_IDLE: begin
                if (clean) begin
                    if (is_store) begin
                        busy = 1'b1;
                        if (opt == MEM_SW) begin
                            if (!dev_mem_busy) begin
                                state_n = ST_WRITE;
                                wdata_n = data_in;
                            end
                        end else begin
                            state_n = ST_MERGE;
                            wdata_n = data_in;
                        end
                    end else begin
                        busy     = dev_mem_busy;
                        data_out = load_align(opt, vaddr[1:0], dev_mem_data_in);
                    end
                end
            end
            ST_MERGE: begin
                if (clean) begin
                    busy = 1'b1;
                    if (!dev_mem_busy) begin
                        wdata_n = store_merge(opt, vaddr[1:0], dev_mem_data_in, wdata);
                        state_n = ST_WRITE;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (clean) begin
                    dev_mem_is_write = 1'b1;
                    busy             = dev_mem_busy;
                    if (!dev_mem_busy) state_n = ST_IDLE;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (!rst) begin
            busy             = dev_mem_busy;
            dev_mem_is_write = 1'b0;
        end
    end

    assign instr_out        = dev_mem_data_in;
    assign dev_mem_addr     = {paddr[31:2], 2'b00};
    assign dev_mem_data_out = wdata;
    assign exc_code         = exc;
    assign unused_bits      = ^{paddr[1:0], sel};

endmodule
